// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction prefetch queue between the instruction RAM and the ID stage
module if_prefetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_allow_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_program_count,
    output logic [31:0] if_to_id_instruction,
    output logic        instruction_ram_request,
    output logic [31:0] instruction_ram_address,
    input  logic        instruction_ram_address_ok,
    input  logic        instruction_ram_data_ok,
    input  logic [31:0] instruction_ram_read_data
);
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [31:0]      r_pc [DEPTH];
    logic [31:0]      r_ins[DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [DEPTH-1:0] r_killed;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW-1:0]    r_fill;
    logic [AW:0]      r_count;
    logic [AW:0]      r_unfilled;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_target;
    logic             r_redirect_pending;
    logic             w_accept;
    logic             w_fill;
    logic             w_head_filled;
    logic             w_pop;
    logic             w_survivor;
    logic [AW:0]      w_total;
    logic [DEPTH-1:0] w_kill;
    assign instruction_ram_request = !reset && (r_count < FULL);
    assign instruction_ram_address = reset ? RESET_PC : r_fetch_pc;
    assign w_accept      = instruction_ram_request && instruction_ram_address_ok;
    assign w_fill        = instruction_ram_data_ok && (r_unfilled != '0);
    assign w_head_filled = (r_count != '0) && (r_filled[r_head] || (w_fill && r_fill == r_head));
    assign w_pop         = !reset && w_head_filled && (r_killed[r_head] || id_allow_in);
    assign if_to_id_valid         = !reset && w_head_filled && !r_killed[r_head];
    assign if_to_id_program_count = reset ? '0 : r_pc[r_head];
    assign if_to_id_instruction   = reset ? '0 : (r_filled[r_head] ? r_ins[r_head] : instruction_ram_read_data);
    assign w_total    = r_count + (AW + 1)'(w_accept);
    assign w_survivor = w_total > (AW + 1)'(w_pop);
    for (genvar k = 0; k < DEPTH; k++) begin : g_kill
        logic [AW-1:0] w_off;
        assign w_off     = AW'(k) - r_head;
        assign w_kill[k] = branch_taken && ({1'b0, w_off} < w_total) && ({1'b0, w_off} > (AW + 1)'(w_pop));
    end
    // entry payload: pc written on accept, instruction written on fill
    always_ff @(posedge clock) begin
        if (w_accept) r_pc[r_tail] <= r_fetch_pc;
        if (w_fill) r_ins[r_fill] <= instruction_ram_read_data;
    end
    // queue pointers, occupancy and per-entry filled/killed flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_filled   <= '0;
            r_killed   <= '0;
        end else begin
            if (w_accept) r_tail <= r_tail + AW'(1);
            if (w_fill) r_fill <= r_fill + AW'(1);
            if (w_pop) r_head <= r_head + AW'(1);
            r_count    <= r_count + (AW + 1)'(w_accept) - (AW + 1)'(w_pop);
            r_unfilled <= r_unfilled + (AW + 1)'(w_accept) - (AW + 1)'(w_fill);
            for (int i = 0; i < DEPTH; i++) begin
                r_filled[i] <= (w_accept && r_tail == AW'(i)) ? 1'b0 : (w_fill && r_fill == AW'(i)) ? 1'b1 : r_filled[i];
                r_killed[i] <= (w_accept && r_tail == AW'(i)) ? w_kill[i] : (r_killed[i] | w_kill[i]);
            end
        end
    end
    // fetch address: sequential, redirected after the delay slot, or held while the delay slot is awaited
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc         <= RESET_PC;
            r_target           <= '0;
            r_redirect_pending <= 1'b0;
        end else if (branch_taken) begin
            if (w_survivor) begin
                r_fetch_pc         <= branch_target;
                r_redirect_pending <= 1'b0;
            end else begin
                r_target           <= branch_target;
                r_redirect_pending <= 1'b1;
            end
        end else if (w_accept) begin
            r_fetch_pc         <= r_redirect_pending ? r_target : r_fetch_pc + 32'd4;
            r_redirect_pending <= 1'b0;
        end
    end
endmodule
